// File: rtl/icache_refill_pkg.sv
// Shared definitions for the instruction-cache refill engine: default
// geometry and the refill state encoding (also used for debug display).
package icache_refill_pkg;

  localparam int REFILL_ADDR_W_DEF     = 32;
  localparam int REFILL_BLK_INSTR_DEF  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_READ = 2'd2,
    ST_DONE = 2'd3
  } refill_state_e;

endpackage

// File: rtl/icache_refill.sv
// Instruction-cache refill engine. On a fetch miss it requests the shared
// byte-wide RAM port, streams one block in byte by byte (little-endian lane
// order), then presents the assembled block with its block-aligned address
// to the cache as a single-cycle fill strobe. A flush aborts an in-flight
// refill; a flush arriving once the block is complete does not stop the fill.
module icache_refill
  import icache_refill_pkg::*;
#(
  parameter int ICACHE_BLK_INSTR = REFILL_BLK_INSTR_DEF,
  parameter int ADDR_W           = REFILL_ADDR_W_DEF
) (
  input  logic                          clk,
  input  logic                          rst_in,
  input  logic                          miss_en,
  input  logic [ADDR_W-1:0]             miss_addr,
  input  logic                          flush,
  output logic                          bus_req,
  input  logic                          bus_gnt,
  output logic [ADDR_W-1:0]             ram_a,
  input  logic [7:0]                    ram_din,
  output logic                          fill_en,
  output logic [ADDR_W-1:0]             fill_addr,
  output logic [32*ICACHE_BLK_INSTR-1:0] fill_data,
  output logic                          busy
);

  localparam int BLK_BYTES = 4 * ICACHE_BLK_INSTR;
  localparam int BLK_BITS  = 8 * BLK_BYTES;
  localparam int OFF_W     = $clog2(BLK_BYTES);
  localparam int CNT_W     = OFF_W + 1;

  localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'(BLK_BYTES - 1);
  localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(BLK_BYTES - 1);

  refill_state_e     state;
  refill_state_e     state_nxt;
  logic [ADDR_W-1:0] base;
  logic [CNT_W-1:0]  issue_cnt;
  logic [CNT_W-1:0]  recv_cnt;
  logic [BLK_BITS-1:0] blk_buf;
  logic [OFF_W-1:0]  issue_off;
  logic              capture;

  // A byte is in flight whenever more addresses were issued than bytes taken;
  // once every address has gone out the read address parks on the last byte.
  assign capture   = (state == ST_READ) && (recv_cnt < issue_cnt);
  assign issue_off = issue_cnt[CNT_W-1] ? {OFF_W{1'b1}} : issue_cnt[OFF_W-1:0];

  // State register; reset abandons any refill and returns to idle.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Block base latch, issue/receive counters and per-byte-lane block buffer.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      base      <= '0;
      issue_cnt <= '0;
      recv_cnt  <= '0;
      blk_buf   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (miss_en && !flush) begin
            base <= miss_addr & ~OFF_MASK;
          end
        end
        ST_REQ: begin
          issue_cnt <= '0;
          recv_cnt  <= '0;
        end
        ST_READ: begin
          if (!issue_cnt[CNT_W-1]) begin
            issue_cnt <= issue_cnt + 1'b1;
          end
          if (capture) begin
            blk_buf[8*recv_cnt[OFF_W-1:0] +: 8] <= ram_din;
            recv_cnt <= recv_cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Next-state decode plus outputs, which depend only on registered state so
  // no input ever reaches an output combinationally.
  always_comb begin
    state_nxt = state;
    bus_req   = 1'b0;
    busy      = 1'b0;
    ram_a     = '0;
    fill_en   = 1'b0;
    fill_addr = '0;
    fill_data = '0;
    case (state)
      ST_IDLE: begin
        if (miss_en && !flush) begin
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        bus_req = 1'b1;
        busy    = 1'b1;
        if (flush) begin
          state_nxt = ST_IDLE;
        end else if (bus_gnt) begin
          state_nxt = ST_READ;
        end
      end
      ST_READ: begin
        bus_req = 1'b1;
        busy    = 1'b1;
        ram_a   = base | ADDR_W'(issue_off);
        if (flush) begin
          state_nxt = ST_IDLE;
        end else if (capture && (recv_cnt == LAST_BYTE)) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        busy      = 1'b1;
        fill_en   = 1'b1;
        fill_addr = base;
        fill_data = blk_buf;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_icache_refill.sv
// Self-checking bench for icache_refill: directed miss/flush/reset scenarios,
// a registered RAM model, a programmable-latency arbiter, and a scoreboard
// that matches every fill strobe against the expected block, address and cycle.
module tb_icache_refill;

  typedef struct {
    logic [31:0]  addr;
    logic [511:0] data;
    int           cycle;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_in;
  logic         miss_en;
  logic [31:0]  miss_addr;
  logic         flush;
  logic         bus_req;
  logic         bus_gnt;
  logic [31:0]  ram_a;
  logic [7:0]   ram_din;
  logic         fill_en;
  logic [31:0]  fill_addr;
  logic [511:0] fill_data;
  logic         busy;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   gnt_delay = 0;
  int   gnt_cnt = 0;
  logic prev_fill = 1'b0;
  logic [31:0] last_word0 = '0;
  exp_t sb_q[$];

  icache_refill #(
    .ICACHE_BLK_INSTR(16),
    .ADDR_W(32)
  ) dut (
    .clk(clk),
    .rst_in(rst_in),
    .miss_en(miss_en),
    .miss_addr(miss_addr),
    .flush(flush),
    .bus_req(bus_req),
    .bus_gnt(bus_gnt),
    .ram_a(ram_a),
    .ram_din(ram_din),
    .fill_en(fill_en),
    .fill_addr(fill_addr),
    .fill_data(fill_data),
    .busy(busy)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Cycle index; after posedge+1 it names the cycle currently in progress.
  always @(posedge clk) cyc <= cyc + 1;

  // RAM content: low address byte, with bit 7 flipped when address bit 13 is
  // set so blocks in different regions carry distinguishable data.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    return a[7:0] ^ {a[13], 7'b0};
  endfunction

  function automatic logic [511:0] exp_block(input logic [31:0] base);
    logic [511:0] b;
    b = '0;
    for (int k = 0; k < 64; k++) begin
      b[8*k +: 8] = mem_byte(base | 32'(k));
    end
    return b;
  endfunction

  // Registered RAM: data for an address appears the cycle after it is driven.
  always @(posedge clk) ram_din <= mem_byte(ram_a);

  // Arbiter: grants gnt_delay cycles after the request rises, then holds grant.
  always @(posedge clk) begin
    if (!bus_req) gnt_cnt <= 0;
    else if (gnt_cnt < gnt_delay) gnt_cnt <= gnt_cnt + 1;
  end
  assign bus_gnt = bus_req && (gnt_cnt >= gnt_delay);

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cycles(input int n);
    repeat (n) next_cycle();
  endtask

  task automatic push_expect(input logic [31:0] addr, input int cycle);
    exp_t e;
    e.addr  = addr & ~32'h3F;
    e.data  = exp_block(e.addr);
    e.cycle = cycle;
    sb_q.push_back(e);
  endtask

  // Raise a miss in the current cycle (DUT idle) and record the expected fill.
  task automatic applyStimulus(input logic [31:0] addr, input int delay,
                               input bit expect_fill, output int m);
    gnt_delay = delay;
    miss_addr = addr;
    miss_en   = 1'b1;
    m         = cyc;
    if (expect_fill) push_expect(addr, m + 67 + delay);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while (busy && n < budget) begin
      next_cycle();
      n++;
    end
    checkOutput({name, "_idle"}, 64'(busy), 64'd0);
  endtask

  // Monitor: every fill strobe is popped against the scoreboard and checked
  // for address, data, arrival cycle and never being back-to-back.
  always @(negedge clk) begin
    exp_t e;
    if (fill_en) begin
      checkOutput("fill_not_consecutive", 64'(prev_fill), 64'd0);
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_fill: got addr 0x%0h at cycle %0d, expected no fill", fill_addr, cyc);
      end else begin
        e = sb_q.pop_front();
        checkOutput("fill_addr", 64'(fill_addr), 64'(e.addr));
        checkOutput("fill_cycle", 64'(cyc), 64'(e.cycle));
        tests++;
        if (fill_data !== e.data) begin
          fails++;
          $display("[TB] FAIL fill_data: got 0x%0h, expected 0x%0h", fill_data, e.data);
        end
        last_word0 = fill_data[31:0];
      end
    end
    prev_fill = fill_en;
  end

  // Watchdog so a stuck DUT can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios.
  initial begin
    int m;
    rst_in    = 1'b1;
    miss_en   = 1'b0;
    miss_addr = '0;
    flush     = 1'b0;
    run_cycles(3);
    checkOutput("rst_bus_req", 64'(bus_req), 64'd0);
    checkOutput("rst_ram_a", 64'(ram_a), 64'd0);
    checkOutput("rst_fill_en", 64'(fill_en), 64'd0);
    checkOutput("rst_fill_addr", 64'(fill_addr), 64'd0);
    checkOutput("rst_fill_data_zero", 64'(|fill_data), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    rst_in = 1'b0;
    next_cycle();

    // Immediate grant, miss at 0x1234.
    applyStimulus(32'h0000_1234, 0, 1'b1, m);
    next_cycle();
    miss_en = 1'b0;
    checkOutput("t1_bus_req", 64'(bus_req), 64'd1);
    checkOutput("t1_busy", 64'(busy), 64'd1);
    next_cycle();
    for (int k = 0; k < 64; k++) begin
      checkOutput("t1_ram_a", 64'(ram_a), 64'(32'h0000_1200 + 32'(k)));
      next_cycle();
    end
    checkOutput("t1_ram_a_hold", 64'(ram_a), 64'h0000_123F);
    wait_idle(10, "t1");
    checkOutput("t1_word0", 64'(last_word0), 64'h0302_0100);

    // Grant delayed by 10 cycles.
    applyStimulus(32'h4000_0A10, 10, 1'b1, m);
    next_cycle();
    miss_en = 1'b0;
    for (int i = 0; i < 11; i++) begin
      checkOutput("t2_bus_req_wait", 64'(bus_req), 64'd1);
      next_cycle();
    end
    checkOutput("t2_ram_a_first", 64'(ram_a), 64'h4000_0A00);
    next_cycle();
    checkOutput("t2_ram_a_second", 64'(ram_a), 64'h4000_0A01);
    wait_idle(80, "t2");

    // Flush in the 30th READ cycle, then a clean miss at 0x2000.
    applyStimulus(32'h0000_1234, 0, 1'b0, m);
    next_cycle();
    miss_en = 1'b0;
    run_cycles(30);
    flush = 1'b1;
    next_cycle();
    flush = 1'b0;
    checkOutput("t3_bus_req_drop", 64'(bus_req), 64'd0);
    checkOutput("t3_busy_drop", 64'(busy), 64'd0);
    checkOutput("t3_no_fill", 64'(fill_en), 64'd0);
    run_cycles(3);
    applyStimulus(32'h0000_2000, 0, 1'b1, m);
    next_cycle();
    miss_en = 1'b0;
    wait_idle(80, "t3");
    checkOutput("t3_word0", 64'(last_word0), 64'h8382_8180);

    // Flush while the fill strobe is up.
    applyStimulus(32'h0000_3F00, 0, 1'b1, m);
    next_cycle();
    miss_en = 1'b0;
    run_cycles(66);
    checkOutput("t4_fill_en", 64'(fill_en), 64'd1);
    flush = 1'b1;
    next_cycle();
    flush = 1'b0;
    checkOutput("t4_busy_after", 64'(busy), 64'd0);

    // miss_en held through a refill; address change while busy is ignored.
    applyStimulus(32'h5000_0040, 0, 1'b1, m);
    push_expect(32'h5000_0080, m + 68 + 67);
    run_cycles(20);
    miss_addr = 32'h5000_0080;
    run_cycles(48);
    checkOutput("t5_idle_gap", 64'(busy), 64'd0);
    next_cycle();
    checkOutput("t5_busy_again", 64'(busy), 64'd1);
    miss_en = 1'b0;
    wait_idle(80, "t5");

    // Reset mid-READ, then a full refill of the same block.
    applyStimulus(32'h6000_0100, 0, 1'b0, m);
    next_cycle();
    miss_en = 1'b0;
    run_cycles(19);
    rst_in = 1'b1;
    next_cycle();
    checkOutput("t6_bus_req", 64'(bus_req), 64'd0);
    checkOutput("t6_ram_a", 64'(ram_a), 64'd0);
    checkOutput("t6_fill_en", 64'(fill_en), 64'd0);
    checkOutput("t6_fill_addr", 64'(fill_addr), 64'd0);
    checkOutput("t6_fill_data_zero", 64'(|fill_data), 64'd0);
    checkOutput("t6_busy", 64'(busy), 64'd0);
    rst_in = 1'b0;
    next_cycle();
    applyStimulus(32'h6000_0100, 0, 1'b1, m);
    next_cycle();
    miss_en = 1'b0;
    wait_idle(80, "t6");

    run_cycles(3);
    checkOutput("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/icache_refill.md
# icache_refill

Refill engine that sits directly upstream of the instruction cache. On a fetch miss it wins the shared byte-wide RAM port through the memory arbiter and streams one cache block in, byte by byte. It assembles the bytes into a full block and then writes block plus block-aligned address into the cache in a single-cycle fill pulse. A flush, for example on branch redirect, aborts any refill in progress.

## Interface
Parameters:
- ICACHE_BLK_INSTR, default 16: instructions per block; block is BLK_BYTES = 4*ICACHE_BLK_INSTR bytes (64) and 32*ICACHE_BLK_INSTR bits (512).
- ADDR_W, default 32: address width.

Ports:
- clk  in  1  system clock.
- rst_in  in  1  synchronous, active-high reset.
- miss_en  in  1  fetch miss request; IF holds it until the cache hits.
- miss_addr  in  ADDR_W  missing instruction address (any alignment within block).
- flush  in  1  abort current refill (pipeline redirect).
- bus_req  out  1  request/hold of RAM port to arbiter.
- bus_gnt  in  1  arbiter grant; once given, stays high while bus_req stays high.
- ram_a  out  ADDR_W  byte read address to RAM.
- ram_din  in  8  RAM read data, valid the cycle after ram_a is presented.
- fill_en  out  1  one-cycle block write strobe to the cache.
- fill_addr  out  ADDR_W  block-aligned address of the fill (low log2(BLK_BYTES) bits zero).
- fill_data  out  32*ICACHE_BLK_INSTR  assembled block.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, REQ, READ, DONE.
- IDLE: when miss_en=1 and flush=0, latch base = miss_addr with low 6 bits cleared, then go to REQ. Otherwise stay.
- REQ: bus_req=1. On bus_gnt=1 go to READ with issue_cnt=0 and recv_cnt=0. A bus_gnt received while not in REQ/READ is ignored.
- READ: bus_req=1.
  - ram_a = base | issue_cnt[5:0]. No carry into upper bits.
  - issue_cnt (7 bit) increments each cycle until it reaches 64; after that ram_a holds base|63.
  - Each cycle after an issue, ram_din is written into byte lane recv_cnt of the block buffer (bits 8*k+7:8*k), and recv_cnt increments.
  - When byte 63 is captured, go to DONE.
- DONE: fill_en=1, fill_addr=base, fill_data=buffer, bus_req=0. Go to IDLE the next cycle.
- Byte order is little-endian. Instruction j of the block occupies fill_data[32j+31:32j].
- miss_en while busy is ignored. No queueing of requests.
- flush=1 in REQ or READ: next state is IDLE, bus_req deasserts the next cycle, no fill occurs, and the partial buffer is discarded.
- flush=1 in DONE: the fill still completes. The written block is valid memory content.
- flush and miss_en together in IDLE: flush wins and nothing is latched.
- rst_in mid-refill: return to IDLE in the next cycle and abandon the buffer.

## Timing
- All outputs are registered or decoded from state only. There are no combinational paths from input to output.
- Reset values: bus_req=0, ram_a=0, fill_en=0, fill_addr=0, fill_data=0, busy=0, state IDLE.
- Cycle sequence with miss accepted in cycle M:
  - REQ from M+1; bus_req high from M+1.
  - Grant sampled in cycle G ≥ M+1.
  - ram_a carries bytes 0..63 in cycles G+1..G+64.
  - Bytes captured at the ends of cycles G+2..G+65.
  - fill_en high in cycle G+66 only.
  - IDLE and busy=0 from G+67.
- Minimum miss-to-fill latency is 67 cycles (grant in M+1, fill in M+67).
- fill_en is never high for two consecutive cycles.

## Structure
- param.v supplies ADDR_WIDTH, ICACHE_BLK_WIDTH, ICACHE_OFFSET_RANGE and the block byte-offset width (6). It also holds the state encodings, defined as localparams shared for debug display.
- This is a single module with no sub-module. The block buffer is a flat register vector written per byte lane.

## Test plan
- Reset, then idle: all outputs 0. miss_en=1, miss_addr=0x0000_1234, grant immediate: ram_a steps 0x1200..0x123F. With RAM byte k = k, fill_en pulses once with fill_addr=0x1200 and fill_data[31:0]=0x03020100. Fill arrives 67 cycles after the miss.
- Grant delayed 10 cycles: bus_req stays high and ram_a does not advance before the grant. Fill arrives in cycle G+66.
- flush in the 30th READ cycle: bus_req low the next cycle and no fill_en. A new miss at 0x0000_2000 then completes correctly with no stale bytes in the block.
- flush during DONE: fill_en still pulses with the correct block.
- miss_en held high through an entire refill and after it: exactly one refill per acceptance. A second refill starts only from IDLE with freshly latched miss_addr.
- rst_in asserted mid-READ: all outputs at reset values next cycle. A subsequent miss produces a full, correct block.
